// File: rtl/ahb_decoder_pipe.sv
// AHB-Lite address decoder with registered data-phase owner, boot remap,
// built-in default slave (two-cycle ERROR response) and decode-error logging.
module ahb_decoder_pipe #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SLAVE_NUM   = 7,
  parameter logic [SLAVE_NUM*ADDR_W-1:0] LOW_ADDR = {
    32'h0000_6000, 32'h0000_5000, 32'h0000_4000, 32'h0000_3000,
    32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [SLAVE_NUM*ADDR_W-1:0] HIGH_ADDR = {
    32'h0000_6FFF, 32'h0000_5FFF, 32'h0000_4FFF, 32'h0000_3FFF,
    32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF},
  parameter int unsigned REMAP_SLAVE = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [ADDR_W-1:0]    haddr,
  input  logic [1:0]           htrans,
  input  logic                 hready,
  input  logic                 hremap,
  output logic [SLAVE_NUM-1:0] hsel,
  output logic                 default_slv_sel,
  output logic [SLAVE_NUM:0]   dphase_sel,
  output logic                 def_hreadyout,
  output logic                 def_hresp,
  output logic [CNT_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    err_addr
);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t               state;
  logic [SLAVE_NUM-1:0] hit;
  logic                 any_hit;
  logic                 found;
  logic                 err_enter;

  // Region compare; both bounds inclusive over the full address width.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      hit[i] = (haddr >= LOW_ADDR[i*ADDR_W +: ADDR_W]) &&
               (haddr <= HIGH_ADDR[i*ADDR_W +: ADDR_W]);
    end
  end

  assign any_hit = |hit;

  // Lowest index wins on overlap; remap then moves a region-0 hit elsewhere.
  always_comb begin
    hsel  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      if (hit[i] && !found) begin
        hsel[i] = 1'b1;
        found   = 1'b1;
      end
    end
    if (hremap && hit[0]) begin
      hsel              = '0;
      hsel[REMAP_SLAVE] = 1'b1;
    end
  end

  assign default_slv_sel = ~any_hit & htrans[1];

  // ERR1 is never re-entered directly from ERR1; the address phase is only
  // re-sampled on OK or ERR2 cycles.
  assign err_enter = (state != ST_ERR1) && hready && default_slv_sel;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dphase_sel <= '0;
      dphase_sel[SLAVE_NUM] <= 1'b1;
    end else if (hready) begin
      if (!any_hit) begin
        dphase_sel <= '0;
        dphase_sel[SLAVE_NUM] <= 1'b1;
      end else begin
        dphase_sel <= {1'b0, hsel};
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state         <= ST_OK;
      def_hreadyout <= 1'b1;
      def_hresp     <= 1'b0;
      err_count     <= '0;
      err_addr      <= '0;
    end else begin
      if (err_enter) begin
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
        err_addr <= haddr;
      end
      case (state)
        ST_OK, ST_ERR2: begin
          if (err_enter) begin
            state         <= ST_ERR1;
            def_hreadyout <= 1'b0;
            def_hresp     <= 1'b1;
          end else begin
            state         <= ST_OK;
            def_hreadyout <= 1'b1;
            def_hresp     <= 1'b0;
          end
        end
        ST_ERR1: begin
          state         <= ST_ERR2;
          def_hreadyout <= 1'b1;
          def_hresp     <= 1'b1;
        end
        default: begin
          state         <= ST_OK;
          def_hreadyout <= 1'b1;
          def_hresp     <= 1'b0;
        end
      endcase
    end
  end

endmodule
